// File: rtl/branch_pc_unit.sv
// branch_pc_unit
//   RV64 branch-resolution and PC-update unit. Accepts one instruction plus
//   its two register operands, evaluates the B-type condition and commits
//   either pc+4 or pc+imm to the architectural PC under a valid/ready
//   handshake. A stall input holds the commit. Counts committed branches
//   and taken branches with saturating counters.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active-low
//   in_valid      instruction/operands valid
//   in_ready      unit can accept (idle)
//   inst          32-bit instruction word
//   rs1_data      value of register inst[19:15]
//   rs2_data      value of register inst[24:20]
//   stall         hold commit while high
//   pc            architectural PC
//   done          one-cycle pulse after a commit edge
//   taken         with done: branch taken
//   illegal       with done: reserved funct3 on branch opcode
//   misaligned    with done: taken target has bit 1 set (PC held)
//   branch_count  committed branch-opcode instructions (saturating)
//   taken_count   committed taken branches (saturating)
module branch_pc_unit #(
  parameter int              XLEN     = 64,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             stall,
  output logic [PC_W-1:0]  pc,
  output logic             done,
  output logic             taken,
  output logic             illegal,
  output logic             misaligned,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t            state, state_next;
  logic [31:0]       inst_q;
  logic [XLEN-1:0]   rs1_q, rs2_q;

  logic              accept, commit;
  logic              is_branch, bad_funct3, cond, taken_c, misaligned_c;
  logic [2:0]        funct3;
  logic [12:0]       imm13;
  logic [PC_W-1:0]   imm_ext, target, pc_plus4, pc_next;

  // FSM next-state and handshake.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC: begin
        if (!stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;
  assign commit = (state == EXEC) && !stall;

  // Decode of the latched instruction.
  assign is_branch  = (inst_q[6:0] == OP_BRANCH);
  assign funct3     = inst_q[14:12];
  assign bad_funct3 = (funct3 == 3'b010) || (funct3 == 3'b011);
  assign imm13      = {inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_ext    = PC_W'($signed(imm13));
  assign target     = pc + imm_ext;
  assign pc_plus4   = pc + PC_W'(4);

  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond = (rs1_q <  rs2_q);
      3'b111:  cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
  end

  assign taken_c      = is_branch && !bad_funct3 && cond;
  // A taken branch to a half-word target is reported and the PC is held.
  assign misaligned_c = taken_c && target[1];
  assign pc_next      = !taken_c ? pc_plus4 : (misaligned_c ? pc : target);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      done         <= 1'b0;
      taken        <= 1'b0;
      illegal      <= 1'b0;
      misaligned   <= 1'b0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      state      <= state_next;
      done       <= commit;
      taken      <= commit && taken_c;
      illegal    <= commit && is_branch && bad_funct3;
      misaligned <= commit && misaligned_c;
      if (commit) begin
        pc <= pc_next;
        if (is_branch && !(&branch_count)) branch_count <= branch_count + 1'b1;
        if (taken_c && !(&taken_count))    taken_count  <= taken_count + 1'b1;
      end
    end
  end

  // NOTE: the operand latch is deliberately left without reset; it is only
  // read in EXEC, which can only be entered through a load of these flops.
  always_ff @(posedge clk) begin
    if (accept) begin
      inst_q <= inst;
      rs1_q  <= rs1_data;
      rs2_q  <= rs2_data;
    end
  end

endmodule
